// File: rtl/usbf_dma_pkg.sv
// Shared types and limits for the USB function DMA request arbiter.
package usbf_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  localparam int BURST_MAX_DEF = 16;
  localparam int N_EP_MAX      = 16;

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational rotate/priority pick over the endpoint request vector.
// USBF_DMA_ARB_FIXED_PRIO_EN: scan from index 0 instead of last_grant+1.
module usbf_rr_pick #(
  parameter int N_EP  = 4,
  parameter int SEL_W = $clog2(N_EP)
) (
  input  logic [N_EP-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  input  logic             exclude_en,
  input  logic [SEL_W-1:0] exclude_idx,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

`ifdef USBF_DMA_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_comb begin
    int base;
    int j;
    logic [SEL_W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
`ifdef USBF_DMA_ARB_FIXED_PRIO_EN
    base  = 0;
`else
    base  = int'(last_grant) + 1;
`endif
    // Walk N_EP candidates starting at base, wrapping modulo N_EP.
    for (int k = 0; k < N_EP; k++) begin
      j = base + k;
      if (j >= N_EP) j = j - N_EP;
      jj = SEL_W'(j);
      if (!found && req[jj] && !(exclude_en && (jj == exclude_idx))) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/usbf_dma_arb.sv
// Arbitrates endpoint DMA requests onto one master dma_req/dma_ack pair,
// round-robin with bounded bursts (fixed priority with USBF_DMA_ARB_FIXED_PRIO_EN).
module usbf_dma_arb
  import usbf_dma_pkg::*;
#(
  parameter  int N_EP      = 4,
  parameter  int BURST_MAX = BURST_MAX_DEF,
  localparam int SEL_W     = $clog2(N_EP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EP-1:0]  ep_dma_req,
  output logic [N_EP-1:0]  ep_dma_ack,
  output logic             dma_req,
  input  logic             dma_ack,
  output logic [SEL_W-1:0] dma_sel,
  output logic             arb_busy
);

  localparam int                CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]  BM_C  = CNT_W'(BURST_MAX);

  arb_state_e       state_q, state_d;
  logic             dma_req_q, dma_req_d;
  logic [SEL_W-1:0] dma_sel_q, dma_sel_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [N_EP-1:0]  sel_onehot;
  logic             cur_req, others_req;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // In SETTLE the current endpoint is excluded so a forced switch never re-picks it.
  usbf_rr_pick #(.N_EP(N_EP), .SEL_W(SEL_W)) u_pick (
    .req         (ep_dma_req),
    .last_grant  (last_grant_q),
    .exclude_en  (state_q == SETTLE),
    .exclude_idx (dma_sel_q),
    .found       (pick_found),
    .idx         (pick_idx)
  );

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N_EP; i++) sel_onehot[i] = (dma_sel_q == SEL_W'(i));
  end

  assign cur_req    = ep_dma_req[dma_sel_q];
  assign others_req = |(ep_dma_req & ~sel_onehot);

  always_comb begin
    state_d      = state_q;
    dma_req_d    = dma_req_q;
    dma_sel_d    = dma_sel_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          dma_sel_d    = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
          dma_req_d    = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (dma_ack) begin
          dma_req_d = 1'b0;
          if (beat_cnt_q != BM_C) beat_cnt_d = beat_cnt_q + CNT_W'(1);
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cur_req && (beat_cnt_q < BM_C)) begin
          dma_req_d = 1'b1;
          state_d   = BUSY;
        end else if (cur_req && !others_req) begin
          // Burst exhausted but nobody else is waiting: start a fresh burst.
          beat_cnt_d = '0;
          dma_req_d  = 1'b1;
          state_d    = BUSY;
        end else if (pick_found) begin
          dma_sel_d    = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
          dma_req_d    = 1'b1;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        dma_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dma_req_q    <= 1'b0;
      dma_sel_q    <= '0;
      last_grant_q <= SEL_W'(N_EP - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      dma_req_q    <= dma_req_d;
      dma_sel_q    <= dma_sel_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign ep_dma_ack = ((state_q == BUSY) && dma_ack) ? sel_onehot : '0;
  assign dma_req    = dma_req_q;
  assign dma_sel    = dma_sel_q;
  assign arb_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Directed bench for usbf_dma_arb: phase-level model checked every cycle plus literal pins.
module tb_usbf_dma_arb;
  localparam int N  = 4;
  localparam int BM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] ep_dma_req = '0;
  logic [N-1:0] ep_dma_ack;
  logic         dma_req;
  logic         dma_ack = 1'b0;
  logic [1:0]   dma_sel;
  logic         arb_busy;

  always #5 clk = ~clk;

  usbf_dma_arb #(.N_EP(N), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst        (rst),
    .ep_dma_req (ep_dma_req),
    .ep_dma_ack (ep_dma_ack),
    .dma_req    (dma_req),
    .dma_ack    (dma_ack),
    .dma_sel    (dma_sel),
    .arb_busy   (arb_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: phase 0 = no grant, 1 = waiting for a beat, 2 = settle cycle after a beat.
  int m_phase, m_sel, m_last, m_beats;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i[1:0]] = 1'b1;
    return v;
  endfunction

  function automatic int rr_next(input logic [N-1:0] r, input int after);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (after + k) % N;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_sel = 0; m_last = N - 1; m_beats = 0;
    end else begin
      case (m_phase)
        0: if (ep_dma_req != '0) begin
             m_sel = rr_next(ep_dma_req, m_last); m_last = m_sel; m_beats = 0; m_phase = 1;
           end
        1: if (dma_ack) begin
             m_beats = (m_beats < BM) ? m_beats + 1 : BM; m_phase = 2;
           end
        default: begin
          if (ep_dma_req[m_sel[1:0]] && m_beats < BM) m_phase = 1;
          else if (ep_dma_req == onehot(m_sel)) begin m_beats = 0; m_phase = 1; end
          else if (ep_dma_req != '0) begin
            m_sel = rr_next(ep_dma_req, m_sel); m_last = m_sel; m_beats = 0; m_phase = 1;
          end else m_phase = 0;
        end
      endcase
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  bit         auto_ack = 0;
  bit         gap_on = 0;
  int         cur_gap = 0, max_gap = 0;
  logic [N-1:0] last_ack;
  int         beats[$];

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: compare against the model mid-cycle, then return just after the next rising edge.
  task automatic tick();
    logic [N-1:0] exp_ack;
    if (auto_ack) dma_ack = dma_req;
    @(negedge clk);
    exp_ack = (m_phase == 1 && dma_ack) ? onehot(m_sel) : '0;
    check("dma_req", int'(dma_req), (m_phase == 1) ? 1 : 0);
    check("arb_busy", int'(arb_busy), (m_phase != 0) ? 1 : 0);
    check("ep_dma_ack", int'(ep_dma_ack), int'(exp_ack));
    if (m_phase == 1) check("dma_sel", int'(dma_sel), m_sel);
    last_ack = ep_dma_ack;
    if (ep_dma_ack != '0) beats.push_back(idx_of(ep_dma_ack));
    if (gap_on) begin
      if (!dma_req) cur_gap++;
      else begin
        if (cur_gap > max_gap) max_gap = cur_gap;
        cur_gap = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ep_dma_req = '0; dma_ack = 1'b0; auto_ack = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    beats.delete();
  endtask

  task automatic run_beats(input int n, input int budget, input string nm);
    int t;
    t = 0;
    while (beats.size() < n && t < budget) begin tick(); t++; end
    check(nm, beats.size() >= n ? 1 : 0, 1);
  endtask

  initial begin
    int exp3[12];
    int exp5[8];
    exp3 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    exp5 = '{0, 0, 0, 0, 2, 2, 2, 2};

    // Reset state
    tick(); tick();
    check("rst_dma_req", int'(dma_req), 0);
    check("rst_dma_sel", int'(dma_sel), 0);
    check("rst_arb_busy", int'(arb_busy), 0);
    check("rst_ep_ack", int'(ep_dma_ack), 0);
    rst = 1'b1;
    tick();

    // Single requester ep1, ack routing, one-cycle settle gap
    ep_dma_req = 4'b0010;
    tick();
    check("t1_req", int'(dma_req), 1);
    check("t1_sel", int'(dma_sel), 1);
    dma_ack = 1'b1;
    tick();
    check("t1_ack_route", int'(last_ack), 2);
    check("t1_settle_req", int'(dma_req), 0);
    check("t1_settle_busy", int'(arb_busy), 1);
    dma_ack = 1'b0;
    tick();
    check("t1_rereq", int'(dma_req), 1);
    ep_dma_req = '0; dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    tick();
    check("t1_idle", int'(arb_busy), 0);
    // Ack while idle is ignored
    dma_ack = 1'b1;
    tick();
    check("idle_ack", int'(last_ack), 0);
    check("idle_ack_busy", int'(arb_busy), 0);
    dma_ack = 1'b0;

    // Two simultaneous requesters: ep0 first, then ep2
    do_reset();
    ep_dma_req = 4'b0101;
    tick();
    check("t2_first", int'(dma_sel), 0);
    dma_ack = 1'b1;
    tick();
    ep_dma_req = 4'b0100; dma_ack = 1'b0;
    tick();
    check("t2_second", int'(dma_sel), 2);
    check("t2_req", int'(dma_req), 1);
    ep_dma_req = '0; dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    tick();

    // Burst alternation ep0/ep1 in BM-beat bursts
    do_reset();
    ep_dma_req = 4'b0011; auto_ack = 1;
    run_beats(12, 100, "t3_done");
    for (int i = 0; i < 12; i++)
      check($sformatf("t3_beat%0d", i), (i < beats.size()) ? beats[i] : -1, exp3[i]);

    // Lone requester ep3 keeps going past BM with single-cycle gaps
    do_reset();
    ep_dma_req = 4'b1000; auto_ack = 1;
    run_beats(1, 10, "t4_first");
    gap_on = 1; cur_gap = 0; max_gap = 0;
    run_beats(10, 60, "t4_done");
    gap_on = 0;
    for (int i = 0; i < 10; i++)
      check($sformatf("t4_beat%0d", i), (i < beats.size()) ? beats[i] : -1, 3);
    check("t4_max_gap", max_gap, 1);

    // Ack held high through SETTLE cycles must not count extra beats
    do_reset();
    ep_dma_req = 4'b0101; dma_ack = 1'b1;
    run_beats(8, 60, "t5_done");
    for (int i = 0; i < 8; i++)
      check($sformatf("t5_beat%0d", i), (i < beats.size()) ? beats[i] : -1, exp5[i]);

    // Asynchronous reset while BUSY on ep2
    do_reset();
    ep_dma_req = 4'b0100;
    tick();
    check("t6_sel", int'(dma_sel), 2);
    dma_ack = 1'b1;
    #1;
    check("t6_ack_pre", int'(ep_dma_ack), 4);
    #1 rst = 1'b0;
    #1;
    check("t6_async_req", int'(dma_req), 0);
    check("t6_async_sel", int'(dma_sel), 0);
    check("t6_async_busy", int'(arb_busy), 0);
    check("t6_async_ack", int'(ep_dma_ack), 0);
    dma_ack = 1'b0;
    tick();
    ep_dma_req = 4'b1100; rst = 1'b1;
    tick();
    check("t6_regrant", int'(dma_sel), 2);
    check("t6_regrant_req", int'(dma_req), 1);
    ep_dma_req = '0; dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
